// File: rtl/serial_rx_package.sv
`default_nettype none
// ============================================================================
// serial_rx_package: 8N1-style serial receiver assembling 2**AddressWidth words
// into one package, with frame-error, gap-timeout drop and busy reporting.
// Revision 1.0
// ============================================================================
module serial_rx_package #(
    parameter int AddressWidth     = 3,
    parameter int WordWidth        = 8,
    parameter int SerialTimerWidth = 8,
    parameter int GapBits          = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rx,
    output logic [WordWidth*(2**AddressWidth)-1:0] Q,
    output logic                                  valid,
    output logic                                  frameError,
    output logic                                  dropped,
    output logic                                  busy
);

    localparam int WORDS   = 2 ** AddressWidth;
    localparam int PKG_W   = WordWidth * WORDS;
    localparam int IDX_W   = (AddressWidth > 0) ? AddressWidth : 1;
    localparam int BIT_W   = (WordWidth > 1) ? $clog2(WordWidth) : 1;
    localparam int TMR_W   = SerialTimerWidth;
    localparam int GAP_MAX = GapBits * (2 ** SerialTimerWidth);
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'((2 ** (SerialTimerWidth - 1)) - 1);
    localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'((2 ** SerialTimerWidth) - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WordWidth - 1);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_MAX - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic                 meta_q, rxs_q;
    logic [2:0]           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [WordWidth-1:0] data_q, data_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PKG_W-1:0]     pkg_q, pkg_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [PKG_W-1:0]     out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 drop_q, drop_d;
    logic                 w_expired;
    logic [PKG_W-1:0]     w_pkg_next;

    assign w_expired  = (timer_q == '0);
    assign w_pkg_next = (pkg_q << WordWidth) | PKG_W'(data_q);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        data_d  = data_q;
        idx_d   = idx_q;
        pkg_d   = pkg_q;
        gap_d   = gap_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    timer_d = HALF_LOAD;
                    gap_d   = '0;
                end else if (idx_q != '0) begin
                    // Partial package ages out after GapBits idle bit periods.
                    if (gap_q == GAP_LAST) begin
                        idx_d  = '0;
                        pkg_d  = '0;
                        gap_d  = '0;
                        drop_d = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else begin
                    gap_d = '0;
                end
            end
            S_START: begin
                if (w_expired) begin
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        timer_d = FULL_LOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_DATA: begin
                if (w_expired) begin
                    data_d  = (data_q >> 1) | (WordWidth'(rxs_q) << (WordWidth - 1));
                    timer_d = FULL_LOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_STOP: begin
                if (w_expired) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                        pkg_d   = w_pkg_next;
                        if (idx_q == LAST_WORD) begin
                            idx_d   = '0;
                            out_d   = w_pkg_next;
                            valid_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        state_d = S_WAIT_HIGH;
                        ferr_d  = 1'b1;
                        idx_d   = '0;
                        pkg_d   = '0;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q  <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            pkg_q   <= '0;
            gap_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            meta_q  <= rx;
            rxs_q   <= meta_q;
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            pkg_q   <= pkg_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            drop_q  <= drop_d;
        end
    end

    assign Q          = out_q;
    assign valid      = valid_q;
    assign frameError = ferr_q;
    assign dropped    = drop_q;
    assign busy       = (state_q != S_IDLE) || (idx_q != '0);

endmodule
`default_nettype wire

// File: doc/serial_rx_package.md
SERIAL_RX_PACKAGE -- requirements
Module: serial_rx_package

Interface
REQ-001 SHALL have parameter AddressWidth, default 3, meaning a package holds 2**AddressWidth words.
REQ-002 SHALL have parameter WordWidth, default 8, meaning data bits per serial frame.
REQ-003 SHALL have parameter SerialTimerWidth, default 8, meaning one bit period is 2**SerialTimerWidth clk cycles.
REQ-004 SHALL have parameter GapBits, default 16, meaning the inter-word idle timeout in bit periods.
REQ-005 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port Q, output, WordWidth*2**AddressWidth, the last complete package.
REQ-009 SHALL have port valid, output, 1, a one-cycle pulse when Q is updated.
REQ-010 SHALL have port frameError, output, 1, a one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port dropped, output, 1, a one-cycle pulse when a partial package is discarded by timeout.
REQ-012 SHALL have port busy, output, 1, high while a frame or a partial package is in progress.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer, both flops resetting to 1; all decisions use the synchronized value rxs.
REQ-014 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 In IDLE, when rxs is 0, SHALL go to START and load the bit timer with a half period of 2**(SerialTimerWidth-1) cycles.
REQ-016 In START, at timer expiry, SHALL go to DATA with a full-period timer if rxs is 0; if rxs is 1 (false start), SHALL return to IDLE with no output pulse.
REQ-017 In DATA, SHALL sample rxs at each full-period expiry, receive exactly WordWidth bits LSB first, then go to STOP.
REQ-018 In STOP, at full-period expiry with rxs 1, SHALL append the word to the package shift register (shift left by WordWidth, new word in the LSBs), increment the word index, and go to IDLE.
REQ-019 In STOP, at expiry with rxs 0, SHALL pulse frameError, clear the word index and partial package, and go to WAIT_HIGH.
REQ-020 In WAIT_HIGH, SHALL stay until rxs is 1, then go to IDLE; no start detection is allowed in this state.
REQ-021 When the word index wraps from 2**AddressWidth-1 to 0 in STOP, SHALL load Q with the completed package and assert valid on the next clk edge for exactly one cycle.
REQ-022 The first word received SHALL occupy the most-significant word of Q.
REQ-023 Q SHALL hold its value between valid pulses and SHALL never expose a partial package.
REQ-024 In IDLE with a nonzero word index, SHALL count idle cycles; on reaching GapBits*2**SerialTimerWidth it SHALL clear the index and pulse dropped once; a start bit SHALL reset this count.
REQ-025 busy SHALL be 1 when state is not IDLE or the word index is nonzero.
REQ-026 Timers and counters SHALL be exactly wide enough for their maximum value and SHALL not wrap mid-frame.
REQ-027 With AddressWidth 0, every good frame SHALL produce valid.

Reset
REQ-028 While rst is 0, SHALL force state IDLE, Q=0, valid=0, frameError=0, dropped=0, busy=0, word index=0, timers=0 and synchronizer=1s.
REQ-029 Reset asserted mid-frame or mid-package SHALL discard all partial data; the first frame after release SHALL be treated as word 0.

Verification (AddressWidth=3, WordWidth=8, SerialTimerWidth=4, i.e. 16 clocks/bit)
REQ-030 Bytes 01,23,45,67,89,AB,CD,EF sent back-to-back -> one valid pulse; Q=0x0123456789ABCDEF; busy falls with valid.
REQ-031 A 4-cycle low glitch on rx in IDLE -> no state change past START, no pulses, Q unchanged.
REQ-032 Byte 0x55 sent with stop bit 0, then the line held low for 40 clocks -> frameError pulses once; no start is accepted until rx returns high; a subsequent 8-byte package is received correctly.
REQ-033 Three bytes sent, then idle for 16*16 clocks -> dropped pulses once and busy=0; the next 8 bytes give valid with those 8 bytes only.
REQ-034 rst pulsed low after 5 bytes -> all outputs 0; a following full 8-byte package yields the correct Q.
REQ-035 Two packages sent back-to-back -> two valid pulses 8 frames apart; Q reflects each package in turn.
